ysyx_22040386_lsu: RTL and testbench
====================================

// Module: ysyx_22040386_lsu
// PURPOSE
//  Load/store unit; the memory-access stage directly downstream of the EXU and upstream of register writeback.
//  Takes the EXU effective address (result) and store data (busB) for one load/store at a time.
//  Runs a req/gnt + rvalid transaction on the data-memory port.
//  Returns the extended load data (or a store ack) to writeback through a valid/ready handshake.
//  Replaces the direct per-cycle pmem_write call, so memory may take multiple cycles.
// PARAMETERS
//  TIMEOUT   255  cycles allowed from entering REQ until mem_rvalid; exceeding it aborts with out_err
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   EXU presents a memory op
//  in_ready     out  1   LSU can accept (IDLE only)
//  in_is_store  in   1   1 = store, 0 = load
//  in_funct3    in   3   RV64 width/sign code (funct3 of the instruction)
//  in_addr      in   64  effective address
//  in_wdata     in   64  store data, right-aligned
//  mem_req      out  1   bus request
//  mem_gnt      in   1   bus accepts request this cycle
//  mem_we       out  1   1 = write
//  mem_addr     out  64  8-byte-aligned address {addr[63:3],3'b0}
//  mem_wdata    out  64  store data shifted to its byte lane
//  mem_wmask    out  8   byte-enable mask
//  mem_rvalid   in   1   read data / write ack valid
//  mem_rdata    in   64  aligned 8-byte read data
//  out_valid    out  1   result ready for writeback
//  out_ready    in   1   writeback consumes result
//  out_rdata    out  64  extended load data; 0 for stores and errors
//  out_err      out  1   misaligned access, illegal funct3 or timeout
// BEHAVIOUR
//  Reset:
//   - State goes to IDLE.
//   - mem_req, mem_we, mem_wmask, out_valid and out_err are 0.
//   - mem_addr, mem_wdata and out_rdata are 0.
//  in_ready is combinational: in_ready = (state == IDLE).
//  FSM IDLE -> REQ -> RESP -> DONE -> IDLE; one operation in flight, no overlap.
//  IDLE: on in_valid & in_ready, latch all in_* fields, then check legality.
//   - Illegal funct3 (load 111; store >= 100) goes to DONE with err=1 and issues no bus access.
//   - Misaligned access goes to DONE with err=1 and issues no bus access.
//     Misaligned means: size 2 with addr[0]!=0, size 4 with addr[1:0]!=0, or size 8 with addr[2:0]!=0.
//   - Otherwise go to REQ.
//  REQ: mem_req=1 and all mem_* outputs held stable until mem_gnt; on mem_gnt go to RESP.
//   - mem_wmask = sizemask << addr[2:0]; sizemask is 01/03/0F/FF for B/H/W/D. mem_we=0 for loads.
//   - mem_wdata = in_wdata << (8*addr[2:0]).
//  RESP: mem_req=0. On mem_rvalid, capture data and go to DONE with err=0.
//   - Load data: lane = mem_rdata >> (8*addr[2:0]).
//   - funct3 000 LB / 001 LH / 010 LW are sign-extended; 011 LD passes through.
//   - funct3 100 LBU / 101 LHU / 110 LWU are zero-extended.
//   - For a store, mem_rvalid is the write ack and mem_rdata is ignored.
//  Timeout: a counter clears on entering REQ and increments every cycle in REQ/RESP.
//   - When it reaches TIMEOUT, go to DONE with err=1 and out_rdata=0, and drop mem_req.
//   - mem_rvalid arriving in the same cycle as the timeout wins (normal completion).
//  DONE: out_valid=1, with out_rdata/out_err stable until out_ready.
//   - On out_valid & out_ready, go to IDLE next cycle.
//  Latency: with gnt and rvalid each arriving on the first possible cycle, out_valid is high 3 cycles after the accept edge.
//  Stray mem_rvalid in IDLE/REQ/DONE is ignored.
//  Reset mid-operation abandons the operation immediately. No late response is captured.
// TESTING
//  LD at 0x8000_0010, gnt+rvalid immediate, rdata=0x1122334455667788
//    -> out_rdata=0x1122334455667788, out_valid 3 cycles after accept.
//  LB at addr ...5 with rdata byte5=0x80 -> out_rdata=0xFFFF_FFFF_FFFF_FF80; same with LBU -> 0x80.
//  SH at addr ...6, in_wdata=0xBEEF -> mem_wmask=0xC0, mem_wdata[63:48]=0xBEEF, mem_we=1; ack gives out_err=0.
//  LW at addr ...2 -> no mem_req ever, out_valid with out_err=1.
//  TIMEOUT=4, mem_gnt=1, mem_rvalid never -> out_err=1 after 4 cycles; a later stray rvalid is ignored.
//  Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0.
//  Then pulse rst_n low during REQ -> mem_req drops at once and in_ready=1.

Source files
------------

// File: rtl/ysyx_22040386_lsu.sv
// Load/store unit: one memory op at a time over a req/gnt + rvalid data port,
// with result returned to writeback through a valid/ready handshake.
module ysyx_22040386_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata,
  output logic        out_err
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_store_q, is_store_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [2:0]         off_q, off_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [63:0]        mem_addr_q, mem_addr_d;
  logic [63:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]         mem_wmask_q, mem_wmask_d;
  logic               out_valid_q, out_valid_d;
  logic [63:0]        out_rdata_q, out_rdata_d;
  logic               out_err_q, out_err_d;

  logic               illegal_c;
  logic               misaligned_c;
  logic [7:0]         size_mask_c;
  logic [63:0]        lane_c;
  logic [63:0]        load_ext_c;
  logic               timeout_hit_c;

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign out_valid = out_valid_q;
  assign out_rdata = out_rdata_q;
  assign out_err   = out_err_q;

  assign timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Legality and byte-lane mask of the op presented on the input port
  always_comb begin
    illegal_c = in_is_store ? in_funct3[2] : (in_funct3 == 3'b111);
    case (in_funct3[1:0])
      2'd0:    begin misaligned_c = 1'b0;            size_mask_c = 8'h01; end
      2'd1:    begin misaligned_c = in_addr[0];      size_mask_c = 8'h03; end
      2'd2:    begin misaligned_c = |in_addr[1:0];   size_mask_c = 8'h0F; end
      default: begin misaligned_c = |in_addr[2:0];   size_mask_c = 8'hFF; end
    endcase
  end

  // Load lane extraction and width/sign extension
  always_comb begin
    lane_c = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext_c = {{56{lane_c[7]}},  lane_c[7:0]};
      3'b001:  load_ext_c = {{48{lane_c[15]}}, lane_c[15:0]};
      3'b010:  load_ext_c = {{32{lane_c[31]}}, lane_c[31:0]};
      3'b100:  load_ext_c = {56'd0, lane_c[7:0]};
      3'b101:  load_ext_c = {48'd0, lane_c[15:0]};
      3'b110:  load_ext_c = {32'd0, lane_c[31:0]};
      default: load_ext_c = lane_c;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    out_valid_d = out_valid_q;
    out_rdata_d = out_rdata_q;
    out_err_d   = out_err_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          is_store_d = in_is_store;
          funct3_d   = in_funct3;
          off_d      = in_addr[2:0];
          if (illegal_c || misaligned_c) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_rdata_d = 64'd0;
          end else begin
            state_d     = REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = in_is_store;
            mem_addr_d  = {in_addr[63:3], 3'b000};
            mem_wdata_d = in_wdata << {in_addr[2:0], 3'b000};
            mem_wmask_d = size_mask_c << in_addr[2:0];
          end
        end
      end
      REQ: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (timeout_hit_c) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
          out_rdata_d = 64'd0;
        end else if (mem_gnt) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
        end
      end
      RESP: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        // A response landing on the timeout cycle still completes normally
        if (mem_rvalid) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_err_d   = 1'b0;
          out_rdata_d = is_store_q ? 64'd0 : load_ext_c;
        end else if (timeout_hit_c) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
          out_rdata_d = 64'd0;
        end
      end
      default: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          out_rdata_d = 64'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 3'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      mem_wmask_q <= 8'd0;
      out_valid_q <= 1'b0;
      out_rdata_q <= 64'd0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      out_valid_q <= out_valid_d;
      out_rdata_q <= out_rdata_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040386_lsu.sv
// Directed bench for the load/store unit; a small responder drives the memory
// port with configurable grant/response delays, expected values are hand-derived.
module tb_ysyx_22040386_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_rdata;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  logic        seen_req;
  logic        s_we;
  logic [7:0]  s_mask;
  logic [63:0] s_wdata;
  logic [63:0] s_addr;
  int          lat;

  ysyx_22040386_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  // Issue one op; grant after gd request cycles, respond rvd cycles into RESP
  // (rvd < 0 means never). Returns the cycle index at which out_valid is seen,
  // counting the cycle right after the accept edge as 1.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] rd,
                        input int gd, input int rvd, output int l);
    int rq = 0;
    int rs = 0;
    bit resp = 1'b0;
    seen_req = 1'b0;
    l = -1;
    @(negedge clk);
    in_valid = 1'b1; in_is_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (out_valid) begin
        l = c;
        break;
      end
      if (resp) begin
        if (rvd >= 0 && rs >= rvd) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd;
        end
        rs++;
      end
      if (mem_req) begin
        seen_req = 1'b1;
        s_we = mem_we; s_mask = mem_wmask; s_wdata = mem_wdata; s_addr = mem_addr;
        if (rq >= gd) begin
          mem_gnt = 1'b1;
          resp = 1'b1;
        end
        rq++;
      end
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_is_store = 1'b0; in_funct3 = 3'd0; in_addr = 64'd0; in_wdata = 64'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0; out_ready = 1'b0;
    s_we = 1'b0; s_mask = 8'd0; s_wdata = 64'd0; s_addr = 64'd0; seen_req = 1'b0;

    #22;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_out_rdata", out_rdata, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // LD, immediate grant and response
    run_op(1'b0, 3'b011, 64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 0, 0, lat);
    check("ld_lat", 64'(lat), 64'd3);
    check("ld_rdata", out_rdata, 64'h1122_3344_5566_7788);
    check("ld_err", 64'(out_err), 64'd0);
    check("ld_addr", s_addr, 64'h8000_0010);
    check("ld_mask", 64'(s_mask), 64'hFF);
    check("ld_we", 64'(s_we), 64'd0);
    retire();
    check("ld_idle_ready", 64'(in_ready), 64'd1);
    check("ld_idle_valid", 64'(out_valid), 64'd0);

    // LB / LBU at byte offset 5
    run_op(1'b0, 3'b000, 64'h8000_0005, 64'd0, 64'h0000_8000_0000_0000, 0, 0, lat);
    check("lb_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_mask", 64'(s_mask), 64'h20);
    check("lb_addr", s_addr, 64'h8000_0000);
    retire();
    run_op(1'b0, 3'b100, 64'h8000_0005, 64'd0, 64'h0000_8000_0000_0000, 0, 0, lat);
    check("lbu_rdata", out_rdata, 64'h80);
    retire();

    // LH / LHU at offset 2, LW / LWU at offset 4
    run_op(1'b0, 3'b001, 64'h1002, 64'd0, 64'h0000_0000_9ABC_0000, 0, 0, lat);
    check("lh_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_9ABC);
    retire();
    run_op(1'b0, 3'b101, 64'h1002, 64'd0, 64'h0000_0000_9ABC_0000, 0, 0, lat);
    check("lhu_rdata", out_rdata, 64'h9ABC);
    retire();
    run_op(1'b0, 3'b110, 64'h1004, 64'd0, 64'h8765_4321_0000_0000, 0, 0, lat);
    check("lwu_rdata", out_rdata, 64'h8765_4321);
    retire();

    // SH at offset 6 with one stalled grant cycle
    run_op(1'b1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 64'hDEAD_DEAD_DEAD_DEAD, 1, 0, lat);
    check("sh_mask", 64'(s_mask), 64'hC0);
    check("sh_wdata", s_wdata, 64'hBEEF_0000_0000_0000);
    check("sh_we", 64'(s_we), 64'd1);
    check("sh_err", 64'(out_err), 64'd0);
    check("sh_rdata", out_rdata, 64'd0);
    check("sh_lat", 64'(lat), 64'd4);
    retire();

    // Misaligned LW, illegal load funct3, illegal store funct3
    run_op(1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 0, 0, lat);
    check("mis_req", 64'(seen_req), 64'd0);
    check("mis_err", 64'(out_err), 64'd1);
    check("mis_lat", 64'(lat), 64'd1);
    retire();
    run_op(1'b0, 3'b111, 64'h8000_0000, 64'd0, 64'd0, 0, 0, lat);
    check("ill_ld_req", 64'(seen_req), 64'd0);
    check("ill_ld_err", 64'(out_err), 64'd1);
    retire();
    run_op(1'b1, 3'b100, 64'h8000_0000, 64'd5, 64'd0, 0, 0, lat);
    check("ill_st_req", 64'(seen_req), 64'd0);
    check("ill_st_err", 64'(out_err), 64'd1);
    retire();

    // Timeout: granted, never answered
    run_op(1'b0, 3'b011, 64'h8000_0040, 64'd0, 64'd0, 0, -1, lat);
    check("to_lat", 64'(lat), 64'd5);
    check("to_err", 64'(out_err), 64'd1);
    check("to_rdata", out_rdata, 64'd0);
    check("to_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("to_stray_rdata", out_rdata, 64'd0);
    check("to_stray_err", 64'(out_err), 64'd1);
    retire();
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("idle_stray_valid", 64'(out_valid), 64'd0);
    check("idle_stray_ready", 64'(in_ready), 64'd1);

    // Response on the timeout cycle completes normally
    run_op(1'b0, 3'b011, 64'h8000_0048, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 2, lat);
    check("edge_lat", 64'(lat), 64'd5);
    check("edge_err", 64'(out_err), 64'd0);
    check("edge_rdata", out_rdata, 64'h0123_4567_89AB_CDEF);
    retire();

    // Hold in DONE with out_ready low
    run_op(1'b0, 3'b010, 64'h1004, 64'd0, 64'h8765_4321_0000_0000, 0, 0, lat);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_rdata", out_rdata, 64'hFFFF_FFFF_8765_4321);
      check("hold_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    retire();

    // Reset pulse while in REQ
    @(negedge clk);
    in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b011; in_addr = 64'h8000_0080;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_req", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_drop", 64'(mem_req), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h7777_7777_7777_7777;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_rdata", out_rdata, 64'd0);

    run_op(1'b0, 3'b011, 64'h8000_0088, 64'd0, 64'hCAFE_F00D_1234_5678, 0, 0, lat);
    check("recover_lat", 64'(lat), 64'd3);
    check("recover_rdata", out_rdata, 64'hCAFE_F00D_1234_5678);
    retire();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
